// File: rtl/calc_pkg.sv
// Shared types and widths for the two-requester calculator arbiter.
package calc_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  // Arbiter FSM state encoding, kept as plain constants for legacy consumers.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/calculator.sv
// Combinational 8-bit arithmetic unit producing a 16-bit result.
// Divide-by-zero is not handled here; the caller overrides that case.
module calculator
  import calc_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  op_t               op,
  output logic [RES_W-1:0]  result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  // Zero-extend operands and select the requested operation.
  always_comb begin
    a_ext  = RES_W'(a);
    b_ext  = RES_W'(b);
    result = '0;
    unique case (op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = b_ext - a_ext;
      OP_MUL:  result = a_ext * b_ext;
      OP_DIV:  result = a_ext / b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one calculator between two requesters.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter logic [15:0] DIV0_VALUE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [1:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        busy
);

  state_t            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q,      grant_d;
  logic [OPND_W-1:0] a_q,          a_d;
  logic [OPND_W-1:0] b_q,          b_d;
  op_t               op_q,         op_d;
  logic [RES_W-1:0]  result_q,     result_d;
  logic              err_q,        err_d;

  logic             sel;
  logic             can_accept;
  logic             handshake;
  logic             rsp_fire;
  logic             div_by_zero;
  logic [RES_W-1:0] calc_result;

  calculator u_calculator (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (calc_result)
  );

  // Pick the requester to serve: sole valid one, else the one not served last.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant_q;
    end
    can_accept = rst_n && (state_q == ST_IDLE);
    req0_ready = can_accept && req0_valid && !sel;
    req1_ready = can_accept && req1_valid && sel;
    handshake  = req0_ready || req1_ready;
  end

  // Next-state, operand capture and result registration.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    err_d        = err_q;
    div_by_zero  = (op_q == OP_DIV) && (b_q == '0);
    rsp_fire     = grant_q ? rsp1_ready : rsp0_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d      = ST_EXEC;
          grant_d      = sel;
          last_grant_d = sel;
          a_d          = sel ? req1_a : req0_a;
          b_d          = sel ? req1_b : req0_b;
          op_d         = op_t'(sel ? req1_op : req0_op);
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        result_d = div_by_zero ? DIV0_VALUE : calc_result;
        err_d    = div_by_zero;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d  = ST_IDLE;
          result_d = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // Route the held result to the granted requester only; others read zero.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    rsp0_valid  = (state_q == ST_RESP) && !grant_q;
    rsp1_valid  = (state_q == ST_RESP) && grant_q;
    rsp0_result = rsp0_valid ? result_q : '0;
    rsp1_result = rsp1_valid ? result_q : '0;
    rsp0_err    = rsp0_valid && err_q;
    rsp1_err    = rsp1_valid && err_q;
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Scoreboard bench for calc_arbiter: directed scenarios followed by random traffic.
module tb_calc_arbiter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } op_s;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
    int          hs_cyc;
  } exp_s;

  logic        clk;
  logic        rst_n;
  logic [1:0]  r_valid;
  logic [7:0]  r_a [2];
  logic [7:0]  r_b [2];
  logic [1:0]  r_op [2];
  logic [1:0]  p_ready;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_result, rsp1_result;
  logic        rsp0_err, rsp1_err;
  logic        busy;

  op_s         pend0[$];
  op_s         pend1[$];
  exp_s        sq[$];
  int          glog[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic        model_last = 1'b1;
  logic        first_seen = 1'b0;
  int unsigned gap_pct = 100;
  int unsigned rdy_pct [2] = '{100, 100};

  calc_arbiter #(.DIV0_VALUE(16'hFFFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (r_valid[0]),
    .req0_ready  (req0_ready),
    .req0_a      (r_a[0]),
    .req0_b      (r_b[0]),
    .req0_op     (r_op[0]),
    .req1_valid  (r_valid[1]),
    .req1_ready  (req1_ready),
    .req1_a      (r_a[1]),
    .req1_b      (r_b[1]),
    .req1_op     (r_op[1]),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (p_ready[0]),
    .rsp0_result (rsp0_result),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (p_ready[1]),
    .rsp1_result (rsp1_result),
    .rsp1_err    (rsp1_err),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the operation rules.
  function automatic logic [16:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int ia = int'(a);
    int ib = int'(b);
    int r  = 0;
    logic e = 1'b0;
    case (op)
      2'd0: r = ia + ib;
      2'd1: r = (ib - ia + 65536) % 65536;
      2'd2: r = ia * ib;
      default: begin
        if (ib == 0) begin r = 65535; e = 1'b1; end
        else r = ia / ib;
      end
    endcase
    return {e, r[15:0]};
  endfunction

  // Monitor: grant fairness, handshake capture, response comparison.
  always @(negedge clk) begin
    logic [1:0]  rv;
    logic [1:0]  pr;
    logic [15:0] rr [2];
    logic [1:0]  re;
    rv = {rsp1_valid, rsp0_valid};
    pr = p_ready;
    rr[0] = rsp0_result; rr[1] = rsp1_result;
    re = {rsp1_err, rsp0_err};
    if (!rst_n) begin
      chk(!req0_ready && !req1_ready, "ready_in_reset", {req1_ready, req0_ready}, 0);
      sq.delete();
      glog.delete();
      model_last = 1'b1;
      first_seen = 1'b0;
    end else begin
      logic busy_exp;
      busy_exp = (sq.size() != 0);
      chk(busy == busy_exp, "busy", busy, busy_exp);
      if (req0_ready || req1_ready) begin
        chk(!(req0_ready && req1_ready), "ready_onehot", {req1_ready, req0_ready}, 1);
        chk(!busy_exp, "ready_while_busy", 1, 0);
      end
      if ((r_valid[0] && req0_ready) || (r_valid[1] && req1_ready)) begin
        int          idx;
        int          exp_idx;
        logic [16:0] rc;
        exp_s        e;
        idx = req1_ready ? 1 : 0;
        if (r_valid[0] && r_valid[1]) exp_idx = model_last ? 0 : 1;
        else exp_idx = r_valid[1] ? 1 : 0;
        chk(idx == exp_idx, "grant", idx, exp_idx);
        model_last = idx[0];
        glog.push_back(idx);
        rc = ref_calc(r_a[idx], r_b[idx], r_op[idx]);
        e.idx = idx; e.res = rc[15:0]; e.err = rc[16]; e.hs_cyc = cyc;
        sq.push_back(e);
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[n]) begin
          chk(sq.size() != 0, "spurious_rsp", n, -1);
          if (sq.size() != 0) begin
            chk(sq[0].idx == n, "rsp_port", n, sq[0].idx);
            chk(rr[n] == sq[0].res, "result", rr[n], sq[0].res);
            chk(re[n] == sq[0].err, "err", re[n], sq[0].err);
            if (!first_seen) begin
              chk(cyc == sq[0].hs_cyc + 2, "latency", cyc - sq[0].hs_cyc, 2);
              first_seen = 1'b1;
            end
            if (pr[n]) begin
              void'(sq.pop_front());
              first_seen = 1'b0;
            end
          end
        end else begin
          chk(rr[n] == 16'd0 && re[n] == 1'b0, "idle_zero", rr[n], 0);
        end
      end
    end
  end

  // Request driver: presents queued operations, holds each until accepted.
  initial begin
    logic [1:0] acc;
    forever begin
      @(negedge clk);
      acc = {r_valid[1] && req1_ready, r_valid[0] && req0_ready};
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        op_s o;
        logic have;
        if (acc[n]) begin
          if (n == 0) void'(pend0.pop_front());
          else void'(pend1.pop_front());
          r_valid[n] = 1'b0;
        end
        have = (n == 0) ? (pend0.size() != 0) : (pend1.size() != 0);
        if (!r_valid[n] && have && ($urandom_range(99) < gap_pct)) begin
          o = (n == 0) ? pend0[0] : pend1[0];
          r_a[n] = o.a; r_b[n] = o.b; r_op[n] = o.op;
          r_valid[n] = 1'b1;
        end
      end
    end
  end

  // Response-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) p_ready[n] = ($urandom_range(99) < rdy_pct[n]);
    end
  end

  task automatic push(input int n, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    op_s o;
    o.a = a; o.b = b; o.op = op;
    if (n == 0) pend0.push_back(o);
    else pend1.push_back(o);
  endtask

  task automatic push_rand(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(255));
      if ($urandom_range(7) == 0) b = 8'd0;
      push(n, 8'($urandom_range(255)), b, 2'($urandom_range(3)));
    end
  endtask

  task automatic wait_drain(input int limit);
    logic done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      done = (pend0.size() == 0) && (pend1.size() == 0) && (sq.size() == 0) && (r_valid == 2'b00);
    end
    chk(done, "drain_timeout", 0, 1);
  endtask

  task automatic wait_inflight(input int limit);
    logic done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      done = (sq.size() != 0);
    end
    chk(done, "handshake_timeout", 0, 1);
  endtask

  task automatic reset_dut(input int cycles);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    r_valid = 2'b00;
    p_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin r_a[n] = '0; r_b[n] = '0; r_op[n] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(!busy && !rsp0_valid && !rsp1_valid, "reset_state", {busy, rsp1_valid, rsp0_valid}, 0);

    // Directed single-requester operations, including divide by zero.
    push(0, 8'd200, 8'd100, 2'b00);
    wait_drain(50);
    push(1, 8'd5, 8'd3, 2'b01);
    push(1, 8'd255, 8'd255, 2'b10);
    wait_drain(50);
    push(0, 8'd17, 8'd0, 2'b11);
    push(0, 8'd17, 8'd5, 2'b11);
    wait_drain(50);

    // Both requesters continuously valid from reset: grants alternate.
    rst_n = 1'b0;
    push_rand(0, 2);
    push_rand(1, 2);
    reset_dut(2);
    wait_drain(100);
    chk(glog.size() == 4, "alt_count", glog.size(), 4);
    if (glog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk(glog[i] == (i % 2), "alt_grant", glog[i], i % 2);
    end

    // Response back-pressure with the other requester waiting.
    begin
      int held = 0;
      rdy_pct[1] = 0;
      push(1, 8'd9, 8'd4, 2'b10);
      wait_inflight(20);
      push(0, 8'd1, 8'd2, 2'b00);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        if (rsp1_valid && busy && !req0_ready) held++;
      end
      chk(held >= 5, "backpressure_hold", held, 5);
      rdy_pct[1] = 100;
      wait_drain(50);
    end

    // Reset during EXEC abandons the operation; next tie goes to req0.
    push(0, 8'd50, 8'd60, 2'b10);
    wait_inflight(20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    push(0, 8'd7, 8'd3, 2'b01);
    push(1, 8'd8, 8'd2, 2'b11);
    wait_drain(100);
    chk(glog.size() >= 1 && glog[0] == 0, "tie_after_reset", glog.size() >= 1 ? glog[0] : -1, 0);

    // Random traffic with random gaps and response back-pressure.
    gap_pct = 50;
    rdy_pct[0] = 60;
    rdy_pct[1] = 60;
    push_rand(0, 25);
    push_rand(1, 25);
    wait_drain(3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: DIV0_VALUE, 16'hFFFF, result returned for a divide with divisor 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a  input  8  (N=0,1) first operand, unsigned.
REQ-007 reqN_b  input  8  (N=0,1) second operand, unsigned.
REQ-008 reqN_op  input  2  (N=0,1) 00 add, 01 subtract (b - a), 10 multiply, 11 divide (a / b).
REQ-009 rspN_valid  output  1  (N=0,1) result for requester N is available.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-011 rspN_result  output  16  (N=0,1) operation result.
REQ-012 rspN_err  output  1  (N=0,1) divide-by-zero flag for the held result.
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally after 1 cycle, RESP->IDLE on rspG_valid & rspG_ready (G = granted requester).
REQ-015 In IDLE, grant goes to the sole valid requester; if both are valid, grant goes to the requester not granted last (round-robin via last_grant register).
REQ-016 reqN_ready is combinational: high only in IDLE and only for the requester selected by REQ-015; both ready never high together.
REQ-017 On handshake, a, b, op and grant index are latched; last_grant updates to the granted index in the same edge.
REQ-018 In EXEC, the latched operands drive the calculator datapath; its 16-bit output is registered into the result register at the EXEC->RESP edge.
REQ-019 Arithmetic: operands zero-extended to 16 bits; add and multiply exact; subtract b - a wraps modulo 2^16 (e.g. a=5, b=3 -> 16'hFFFE); divide truncates toward zero.
REQ-020 Divide with b==0: result = DIV0_VALUE, err=1; all other cases err=0.
REQ-021 Latency: handshake at edge T -> rspG_valid high from the edge at T+2; max throughput one operation per 3 cycles.
REQ-022 In RESP, rspG_valid, rspG_result and rspG_err hold stable until rspG_ready; the non-granted rsp_valid stays 0.
REQ-023 New requests are not accepted in EXEC or RESP; requester valid held during that time is serviced later under REQ-015.
REQ-024 rspG_ready asserted before rspG_valid has no effect; the transaction completes on the first cycle both are high.
REQ-025 rspN_result and rspN_err are 0 whenever rspN_valid is 0.

Reset
REQ-026 rst_n low at a rising edge: FSM -> IDLE, last_grant -> 1 (req0 wins first tie), all rsp*_valid, results, err -> 0, busy -> 0.
REQ-027 Reset during EXEC or RESP abandons the in-flight operation; no response is ever issued for it.
REQ-028 reqN_ready is 0 while rst_n is low.

Structure
REQ-029 Shared package calc_pkg holds the op-code typedef (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state typedef and the 8/16-bit width constants.
REQ-030 The combinational datapath is one sub-module, calculator, instantiated once; divide-by-zero detection lives in calc_arbiter.

Verification
REQ-031 req0: a=200, b=100, op=00, rsp0_ready=1 -> rsp0_valid 2 cycles after handshake, result=300, err=0, held 1 cycle.
REQ-032 req1: a=5, b=3, op=01 -> result=16'hFFFE; a=255, b=255, op=10 -> result=65025.
REQ-033 req0: a=17, b=0, op=11 -> result=16'hFFFF, err=1; a=17, b=5, op=11 -> result=3, err=0.
REQ-034 Both requesters valid continuously from reset -> grants alternate 0,1,0,1; never two ready in one cycle.
REQ-035 rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid/result stable, busy=1, req0_ready=0 throughout.
REQ-036 rst_n pulsed low during EXEC -> no rsp_valid afterwards; next tie grants req0.
